pulse_capture: RTL and testbench



---
 rtl/timer_pkg.sv | 40 ++++
 rtl/edge_sync.sv | 42 ++++
 rtl/pulse_capture.sv | 189 ++++++++++++++++++
 tb/tb_pulse_capture.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the timer / input-capture family: capture FSM states,
// prescaler select encodings and edge-select encodings.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_START = 2'd1,
        ACTIVE     = 2'd2,
        INACTIVE   = 2'd3
    } cap_state_e;

    localparam logic [1:0] PRESC_DIV1   = 2'b00;
    localparam logic [1:0] PRESC_DIV8   = 2'b01;
    localparam logic [1:0] PRESC_DIV64  = 2'b10;
    localparam logic [1:0] PRESC_DIV256 = 2'b11;

    localparam int DIV_1   = 1;
    localparam int DIV_8   = 8;
    localparam int DIV_64  = 64;
    localparam int DIV_256 = 256;

    localparam int PRESC_W = 8;

    localparam logic EDGE_RISE_START = 1'b0;
    localparam logic EDGE_FALL_START = 1'b1;

    // Terminal prescaler value for a select code: a tick fires when the
    // prescaler counter equals this, giving one tick every D clocks.
    function automatic logic [PRESC_W-1:0] presc_last(input logic [1:0] sel);
        logic [PRESC_W-1:0] last;
        case (sel)
            PRESC_DIV1:   last = PRESC_W'(DIV_1 - 1);
            PRESC_DIV8:   last = PRESC_W'(DIV_8 - 1);
            PRESC_DIV64:  last = PRESC_W'(DIV_64 - 1);
            default:      last = PRESC_W'(DIV_256 - 1);
        endcase
        return last;
    endfunction

endpackage

// File: rtl/edge_sync.sv
// Multi-flop synchronizer for an asynchronous pin with registered single-cycle
// rise/fall pulses; reusable for any external timer input.
module edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
        prev_d = sync_q[SYNC_STAGES-1];
        rise_d = sync_q[SYNC_STAGES-1] & ~prev_q;
        fall_d = ~sync_q[SYNC_STAGES-1] & prev_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign rise = rise_q;
    assign fall = fall_q;

endmodule

// File: rtl/pulse_capture.sv
// Input-capture channel: measures active time and full period of the TMI pulse
// train in prescaled ticks and hands each result pair over a valid/ack handshake.
module pulse_capture
    import timer_pkg::*;
#(
    parameter int BIT_WIDTH   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 TMI,
    input  logic                 enable,
    input  logic                 edge_sel,
    input  logic [1:0]           prescale_sel,
    input  logic                 capture_ack,
    input  logic                 flag_clr,
    output logic [BIT_WIDTH-1:0] active_time,
    output logic [BIT_WIDTH-1:0] period,
    output logic                 capture_valid,
    output logic                 ovf,
    output logic                 overrun
);

    localparam logic [BIT_WIDTH-1:0] CNT_MAX = '1;

    logic tmi_rise, tmi_fall;

    edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_edge_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (TMI),
        .rise     (tmi_rise),
        .fall     (tmi_fall)
    );

    cap_state_e           state_q, state_d;
    logic [BIT_WIDTH-1:0] cnt_q, cnt_d;
    logic [PRESC_W-1:0]   presc_q, presc_d;
    logic                 es_q, es_d;
    logic [1:0]           psel_q, psel_d;
    logic [BIT_WIDTH-1:0] shadow_q, shadow_d;
    logic [BIT_WIDTH-1:0] act_q, act_d;
    logic [BIT_WIDTH-1:0] per_q, per_d;
    logic                 valid_q, valid_d;
    logic                 ovf_q, ovf_d;
    logic                 ovr_q, ovr_d;

    logic                 tick;
    logic                 over;
    logic                 start_ev, stop_ev;
    logic                 publish;
    logic                 ovf_set, ovr_set;
    logic [PRESC_W-1:0]   presc_nxt;
    logic [BIT_WIDTH-1:0] cnt_inc;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        presc_d  = presc_q;
        es_d     = es_q;
        psel_d   = psel_q;
        shadow_d = shadow_q;
        act_d    = act_q;
        per_d    = per_q;
        valid_d  = valid_q;
        publish  = 1'b0;
        ovf_set  = 1'b0;
        ovr_set  = 1'b0;

        tick      = (presc_q == presc_last(psel_q));
        presc_nxt = tick ? '0 : presc_q + PRESC_W'(1);
        // cnt_inc already includes the tick landing on this edge, so the value
        // latched on an edge event covers every cycle of the phase.
        cnt_inc   = cnt_q + {{(BIT_WIDTH-1){1'b0}}, tick};
        over      = tick && (cnt_q == CNT_MAX);
        start_ev  = (es_q == EDGE_FALL_START) ? tmi_fall : tmi_rise;
        stop_ev   = (es_q == EDGE_FALL_START) ? tmi_rise : tmi_fall;

        if (!enable) begin
            state_d = IDLE;
            cnt_d   = '0;
            presc_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = WAIT_START;
                    es_d    = edge_sel;
                    psel_d  = prescale_sel;
                    cnt_d   = '0;
                    presc_d = '0;
                end
                WAIT_START: begin
                    if (start_ev) begin
                        state_d = ACTIVE;
                        cnt_d   = '0;
                        presc_d = '0;
                    end
                end
                ACTIVE: begin
                    if (over) begin
                        ovf_set = 1'b1;
                        state_d = WAIT_START;
                        cnt_d   = '0;
                        presc_d = '0;
                    end else begin
                        cnt_d   = cnt_inc;
                        presc_d = presc_nxt;
                        if (stop_ev) begin
                            shadow_d = cnt_inc;
                            state_d  = INACTIVE;
                        end
                    end
                end
                INACTIVE: begin
                    if (over) begin
                        ovf_set = 1'b1;
                        state_d = WAIT_START;
                        cnt_d   = '0;
                        presc_d = '0;
                    end else if (start_ev) begin
                        publish = 1'b1;
                        state_d = ACTIVE;
                        cnt_d   = '0;
                        presc_d = '0;
                    end else begin
                        cnt_d   = cnt_inc;
                        presc_d = presc_nxt;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (valid_q && capture_ack) begin
            valid_d = 1'b0;
        end

        // A pending result (even one being acked this cycle) blocks the new one.
        if (publish) begin
            if (valid_q) begin
                ovr_set = 1'b1;
            end else begin
                act_d   = shadow_q;
                per_d   = cnt_inc;
                valid_d = 1'b1;
            end
        end

        ovf_d = ovf_set | (ovf_q & ~flag_clr);
        ovr_d = ovr_set | (ovr_q & ~flag_clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            presc_q  <= '0;
            es_q     <= 1'b0;
            psel_q   <= 2'b00;
            shadow_q <= '0;
            act_q    <= '0;
            per_q    <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            presc_q  <= presc_d;
            es_q     <= es_d;
            psel_q   <= psel_d;
            shadow_q <= shadow_d;
            act_q    <= act_d;
            per_q    <= per_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
            ovr_q    <= ovr_d;
        end
    end

    assign active_time   = act_q;
    assign period        = per_q;
    assign capture_valid = valid_q;
    assign ovf           = ovf_q;
    assign overrun       = ovr_q;

endmodule

// File: tb/tb_pulse_capture.sv
// Scoreboard bench for pulse_capture: stimulus pushes expected result pairs
// computed from the driven waveform; a monitor pops them on each new publish.
module tb_pulse_capture;

    localparam int BW = 8;
    localparam int SS = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          tmi;
    logic          enable;
    logic          edge_sel;
    logic [1:0]    prescale_sel;
    logic          capture_ack;
    logic          flag_clr;
    logic [BW-1:0] active_time;
    logic [BW-1:0] period;
    logic          capture_valid;
    logic          ovf;
    logic          overrun;

    logic ack_auto;
    logic ack_man;
    bit   auto_ack;

    assign capture_ack = ack_auto | ack_man;

    pulse_capture #(
        .BIT_WIDTH   (BW),
        .SYNC_STAGES (SS)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .TMI           (tmi),
        .enable        (enable),
        .edge_sel      (edge_sel),
        .prescale_sel  (prescale_sel),
        .capture_ack   (capture_ack),
        .flag_clr      (flag_clr),
        .active_time   (active_time),
        .period        (period),
        .capture_valid (capture_valid),
        .ovf           (ovf),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int act;
        int per;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input int actual, input int expected);
        n_cmp++;
        if (actual != expected) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic int div_of(input logic [1:0] sel);
        case (sel)
            2'b00:   return 1;
            2'b01:   return 8;
            2'b10:   return 64;
            default: return 256;
        endcase
    endfunction

    // Expected result of one period: floor of each duration over the divisor.
    task automatic expect_period(input int h, input int l, input int d);
        exp_t e;
        e.act = h / d;
        e.per = (h + l) / d;
        sb.push_back(e);
    endtask

    // Monitor: each rising capture_valid is a new result to score.
    initial begin
        exp_t e;
        bit   prev_v;
        prev_v   = 1'b0;
        ack_auto = 1'b0;
        forever begin
            @(negedge clk);
            ack_auto = 1'b0;
            if (capture_valid && !prev_v) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_publish: got %0d/%0d, expected no result",
                             active_time, period);
                end else begin
                    e = sb.pop_front();
                    check("active_time", int'(active_time), e.act);
                    check("period", int'(period), e.per);
                end
            end
            if (capture_valid && auto_ack) ack_auto = 1'b1;
            prev_v = capture_valid;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic phase(input logic lvl, input int n);
        tmi = lvl;
        repeat (n) @(negedge clk);
    endtask

    // Arms with the pin parked at its inactive level, then scrambles the
    // config inputs to show they are ignored while armed.
    task automatic arm(input bit es, input logic [1:0] psel);
        @(negedge clk);
        enable       = 1'b0;
        edge_sel     = es;
        prescale_sel = psel;
        tmi          = es;
        repeat (6) @(negedge clk);
        enable = 1'b1;
        repeat (4) @(negedge clk);
        edge_sel     = 1'($urandom_range(0, 1));
        prescale_sel = 2'($urandom_range(0, 3));
    endtask

    task automatic disarm();
        enable = 1'b0;
        repeat (6) @(negedge clk);
        check("sb_drain", sb.size(), 0);
    endtask

    task automatic pulse_flag_clr();
        flag_clr = 1'b1;
        @(negedge clk);
        flag_clr = 1'b0;
        @(negedge clk);
    endtask

    task automatic burst(input bit es, input logic [1:0] psel, input int n,
                         input int h_fix, input int l_fix, input int dmax);
        int   d, h, l;
        logic act;
        d   = div_of(psel);
        act = ~es;
        arm(es, psel);
        for (int i = 0; i < n; i++) begin
            h = (h_fix > 0) ? h_fix : $urandom_range(3, dmax);
            l = (l_fix > 0) ? l_fix : $urandom_range(3, dmax);
            expect_period(h, l, d);
            phase(act, h);
            phase(~act, l);
        end
        phase(act, 10);
        disarm();
    endtask

    initial begin
        int lat;
        tmi          = 1'b0;
        enable       = 1'b0;
        edge_sel     = 1'b0;
        prescale_sel = 2'b00;
        flag_clr     = 1'b0;
        ack_man      = 1'b0;
        auto_ack     = 1'b1;
        rst_n        = 1'b1;
        #1 rst_n = 1'b0;
        #3;
        check("rst_active_time", int'(active_time), 0);
        check("rst_period", int'(period), 0);
        check("rst_valid", int'(capture_valid), 0);
        check("rst_ovf", int'(ovf), 0);
        check("rst_overrun", int'(overrun), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // /1 10-40 waveform with publish latency measured from the pin edge
        arm(1'b0, 2'b00);
        expect_period(10, 30, 1);
        phase(1'b1, 10);
        phase(1'b0, 30);
        tmi = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!capture_valid && lat < 40);
        check("publish_latency", lat, SS + 2);
        repeat (10 - lat) @(negedge clk);
        expect_period(10, 30, 1);
        phase(1'b0, 30);
        phase(1'b1, 10);
        disarm();
        check("basic_ovf", int'(ovf), 0);
        check("basic_overrun", int'(overrun), 0);

        burst(1'b0, 2'b01, 2, 80, 160, 0);
        burst(1'b0, 2'b10, 2, 64, 64, 0);

        // count of exactly 2^BW-1 is legal
        burst(1'b0, 2'b00, 1, 100, 155, 0);
        check("max_count_no_ovf", int'(ovf), 0);

        // overrun: second result dropped while first is unacked
        arm(1'b0, 2'b00);
        auto_ack = 1'b0;
        expect_period(10, 30, 1);
        phase(1'b1, 10);
        phase(1'b0, 30);
        phase(1'b1, 12);
        phase(1'b0, 38);
        phase(1'b1, 15);
        phase(1'b0, 10);
        check("ovr_set", int'(overrun), 1);
        check("ovr_valid_held", int'(capture_valid), 1);
        check("ovr_act_held", int'(active_time), 10);
        check("ovr_per_held", int'(period), 40);
        ack_man = 1'b1;
        @(negedge clk);
        ack_man = 1'b0;
        check("ack_drops_valid", int'(capture_valid), 0);
        auto_ack = 1'b1;
        expect_period(15, 35, 1);
        phase(1'b0, 24);
        phase(1'b1, 10);
        disarm();
        check("ovr_sticky", int'(overrun), 1);
        pulse_flag_clr();
        check("ovr_cleared", int'(overrun), 0);

        // overflow: high 300 at /1, then a fresh start edge is required
        arm(1'b0, 2'b00);
        phase(1'b1, 300);
        check("ovf_set", int'(ovf), 1);
        phase(1'b0, 15);
        expect_period(5, 15, 1);
        phase(1'b1, 5);
        phase(1'b0, 15);
        expect_period(5, 15, 1);
        phase(1'b1, 5);
        phase(1'b0, 15);
        phase(1'b1, 10);
        disarm();
        check("ovf_sticky", int'(ovf), 1);
        pulse_flag_clr();
        check("ovf_cleared", int'(ovf), 0);

        // falling-edge start; pin already low at arming is not a start
        @(negedge clk);
        enable       = 1'b0;
        edge_sel     = 1'b1;
        prescale_sel = 2'b00;
        tmi          = 1'b0;
        repeat (6) @(negedge clk);
        enable = 1'b1;
        repeat (10) @(negedge clk);
        phase(1'b1, 13);
        expect_period(7, 13, 1);
        phase(1'b0, 7);
        phase(1'b1, 13);
        expect_period(7, 13, 1);
        phase(1'b0, 7);
        phase(1'b1, 13);
        phase(1'b0, 10);
        disarm();

        // async reset mid-ACTIVE with a result pending
        arm(1'b0, 2'b00);
        auto_ack = 1'b0;
        expect_period(10, 30, 1);
        phase(1'b1, 10);
        phase(1'b0, 30);
        phase(1'b1, 8);
        check("pre_rst_valid", int'(capture_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_active_time", int'(active_time), 0);
        check("arst_period", int'(period), 0);
        check("arst_valid", int'(capture_valid), 0);
        check("arst_ovf", int'(ovf), 0);
        check("arst_overrun", int'(overrun), 0);
        tmi      = 1'b0;
        enable   = 1'b0;
        auto_ack = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        burst(1'b0, 2'b00, 2, 0, 0, 120);

        // enable dropped mid-INACTIVE: no publish, outputs retained
        arm(1'b0, 2'b00);
        expect_period(20, 40, 1);
        phase(1'b1, 20);
        phase(1'b0, 40);
        phase(1'b1, 20);
        phase(1'b0, 15);
        enable = 1'b0;
        phase(1'b1, 20);
        phase(1'b0, 5);
        check("abandon_valid", int'(capture_valid), 0);
        check("abandon_act_kept", int'(active_time), 20);
        check("abandon_per_kept", int'(period), 60);
        check("abandon_drain", sb.size(), 0);

        // randomized bursts
        for (int k = 0; k < 6; k++) begin
            logic [1:0] ps;
            ps = 2'($urandom_range(0, 1));
            burst(1'($urandom_range(0, 1)), ps, 3, 0, 0, (ps == 2'b00) ? 120 : 1000);
        end
        check("rand_no_ovf", int'(ovf), 0);
        check("rand_no_overrun", int'(overrun), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
